octant_core: RTL and testbench

//  Classifies a small point cloud into the 8 octants around a midpoint (octree level-1 split).

---
 rtl/octant_core_if.sv | 35 +++
 rtl/octant_core.sv | 133 +++++++++++++
 tb/tb_octant_core.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/octant_core_if.sv
// Port bundle for octant_core: batch setup inputs plus result-write and status outputs.
// Setup inputs are packed {x, y, z, unused} 16-bit signed fields.
interface octant_core_if #(
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned N_POINTS = 4,
  parameter int unsigned CNT_W    = 16
);
  logic                         en;
  logic [63:0]                  mid_point;
  logic [63:0]                  near_bottom_left;
  logic [63:0]                  far_top_right;
  logic [15:0]                  point_cloud_size;
  logic [N_POINTS*COORD_W-1:0]  points_x;
  logic [N_POINTS*COORD_W-1:0]  points_y;
  logic [N_POINTS*COORD_W-1:0]  points_z;
  logic                         wr_en;
  logic [CNT_W-1:0]             wr_addr;
  logic [3:0]                   wr_data;
  logic [8*CNT_W-1:0]           counts;
  logic [CNT_W-1:0]             oob_count;
  logic                         busy;
  logic                         done;

  modport master (
    output en, mid_point, near_bottom_left, far_top_right, point_cloud_size,
           points_x, points_y, points_z,
    input  wr_en, wr_addr, wr_data, counts, oob_count, busy, done
  );

  modport slave (
    input  en, mid_point, near_bottom_left, far_top_right, point_cloud_size,
           points_x, points_y, points_z,
    output wr_en, wr_addr, wr_data, counts, oob_count, busy, done
  );
endinterface

// File: rtl/octant_core.sv
// Octree level-1 splitter: bins up to N_POINTS latched points into 8 octants around a midpoint,
// one point per cycle, writing a {in_bounds, octant} record per point and keeping per-octant counts.
module octant_core #(
  parameter int unsigned COORD_W  = 16,
  parameter int unsigned N_POINTS = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic         clk,
  input logic         rst_n,
  octant_core_if.slave bus
);
  localparam int unsigned IdxW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  typedef logic signed [COORD_W-1:0] coord_t;
  typedef enum logic [1:0] {StIdle, StRun, StDone, StWait} state_e;

  state_e           state_q, state_d;
  coord_t           mid_q [3];
  coord_t           nbl_q [3];
  coord_t           ftr_q [3];
  coord_t           pt_q  [N_POINTS][3];
  logic [CNT_W-1:0] n_q, idx_q, n_clamp;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] oob_q;
  logic             wr_en_q, done_q;
  logic [CNT_W-1:0] addr_q;
  logic [3:0]       data_q;
  logic             start, step;
  coord_t           cur [3];
  logic [2:0]       oct;
  logic             inb;
  logic             unused_fields;

  assign unused_fields = ^{bus.mid_point[15:0], bus.near_bottom_left[15:0],
                           bus.far_top_right[15:0]};

  assign n_clamp = (bus.point_cloud_size > 16'(N_POINTS)) ? CNT_W'(N_POINTS)
                                                          : CNT_W'(bus.point_cloud_size);

  // Axis 0/1/2 = x/y/z; x lands in octant bit 2.
  always_comb begin
    inb = 1'b1;
    oct = 3'b000;
    for (int a = 0; a < 3; a++) begin
      cur[a]   = pt_q[idx_q[IdxW-1:0]][a];
      oct[2-a] = (cur[a] >= mid_q[a]);
      inb      = inb & (cur[a] >= nbl_q[a]) & (cur[a] <= ftr_q[a]);
    end
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          start   = 1'b1;
          state_d = (n_clamp == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (idx_q == n_q - CNT_W'(1)) state_d = StDone;
      end
      StDone: state_d = StWait;
      StWait: if (!bus.en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      idx_q   <= '0;
      oob_q   <= '0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      for (int j = 0; j < 8; j++) cnt_q[j] <= '0;
      for (int a = 0; a < 3; a++) begin
        mid_q[a] <= '0;
        nbl_q[a] <= '0;
        ftr_q[a] <= '0;
        for (int k = 0; k < N_POINTS; k++) pt_q[k][a] <= '0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StDone);
      wr_en_q <= step;
      if (start) begin
        n_q   <= n_clamp;
        idx_q <= '0;
        oob_q <= '0;
        for (int j = 0; j < 8; j++) cnt_q[j] <= '0;
        for (int a = 0; a < 3; a++) begin
          mid_q[a] <= bus.mid_point[63-16*a -: COORD_W];
          nbl_q[a] <= bus.near_bottom_left[63-16*a -: COORD_W];
          ftr_q[a] <= bus.far_top_right[63-16*a -: COORD_W];
        end
        for (int k = 0; k < N_POINTS; k++) begin
          pt_q[k][0] <= bus.points_x[k*COORD_W +: COORD_W];
          pt_q[k][1] <= bus.points_y[k*COORD_W +: COORD_W];
          pt_q[k][2] <= bus.points_z[k*COORD_W +: COORD_W];
        end
      end
      if (step) begin
        idx_q  <= idx_q + CNT_W'(1);
        addr_q <= idx_q;
        data_q <= {inb, oct};
        // Out-of-bounds points are recorded but only bump the oob counter.
        if (inb) begin
          if (cnt_q[oct] != '1) cnt_q[oct] <= cnt_q[oct] + CNT_W'(1);
        end else if (oob_q != '1) begin
          oob_q <= oob_q + CNT_W'(1);
        end
      end
    end
  end

  for (genvar j = 0; j < 8; j++) begin : g_counts
    assign bus.counts[j*CNT_W +: CNT_W] = cnt_q[j];
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.oob_count = oob_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.done      = done_q;
endmodule

// File: tb/tb_octant_core.sv
// Bench for octant_core: table vectors with fixed expectations, randomized batches checked
// against an arithmetic octant/bounds model, plus held-enable and mid-run reset sequences.
module tb_octant_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  octant_core_if #(.COORD_W(16), .N_POINTS(4), .CNT_W(16)) bus ();

  octant_core #(.COORD_W(16), .N_POINTS(4), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] mid, nbl, ftr;
    logic [15:0] size;
    logic [63:0] px, py, pz;
    int          n;
    logic [15:0] exp_data;
    logic [127:0] exp_counts;
    logic [15:0] exp_oob;
  } vec_t;

  logic [3:0] got_data [4];

  function automatic logic [63:0] pt3(int x, int y, int z);
    return {16'(x), 16'(y), 16'(z), 16'h0000};
  endfunction

  function automatic logic [63:0] pts(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_wr_en"}, bus.wr_en, 0);
    chk({nm, "_wr_addr"}, bus.wr_addr, 0);
    chk({nm, "_wr_data"}, bus.wr_data, 0);
    chk({nm, "_counts"}, bus.counts, 0);
    chk({nm, "_oob"}, bus.oob_count, 0);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
  endtask

  task automatic drive(input vec_t v);
    bus.mid_point        = v.mid;
    bus.near_bottom_left = v.nbl;
    bus.far_top_right    = v.ftr;
    bus.point_cloud_size = v.size;
    bus.points_x         = v.px;
    bus.points_y         = v.py;
    bus.points_z         = v.pz;
  endtask

  // Starts a batch, scrambles inputs once it is latched, and checks every cycle against the model.
  task automatic run_batch(input vec_t v, input int hold, input bit rel);
    int n, last, x, y, z, mx, my, mz, lx, ly, lz, hx, hy, hz, o, k;
    logic [3:0]   er [4];
    int           ec [8];
    int           eo;
    logic [127:0] ecp;
    bit           ib;
    n  = (v.size > 16'd4) ? 4 : int'(v.size);
    mx = $signed(v.mid[63:48]); my = $signed(v.mid[47:32]); mz = $signed(v.mid[31:16]);
    lx = $signed(v.nbl[63:48]); ly = $signed(v.nbl[47:32]); lz = $signed(v.nbl[31:16]);
    hx = $signed(v.ftr[63:48]); hy = $signed(v.ftr[47:32]); hz = $signed(v.ftr[31:16]);
    for (int j = 0; j < 8; j++) ec[j] = 0;
    eo = 0;
    for (int i = 0; i < 4; i++) begin
      x  = $signed(v.px[i*16 +: 16]);
      y  = $signed(v.py[i*16 +: 16]);
      z  = $signed(v.pz[i*16 +: 16]);
      o  = (x >= mx ? 4 : 0) + (y >= my ? 2 : 0) + (z >= mz ? 1 : 0);
      ib = (x >= lx && x <= hx && y >= ly && y <= hy && z >= lz && z <= hz);
      er[i] = {ib, 3'(o)};
      if (i < n) begin
        if (ib) ec[o]++;
        else eo++;
      end
    end
    ecp = '0;
    for (int j = 0; j < 8; j++) ecp |= 128'(ec[j]) << (j * 16);

    @(negedge clk);
    drive(v);
    bus.en = 1'b1;
    if (rel) rst_n = 1'b1;
    last = ((n + 2) > hold ? (n + 2) : hold) + 4;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.points_x         = {$urandom, $urandom};
        bus.points_y         = {$urandom, $urandom};
        bus.points_z         = {$urandom, $urandom};
        bus.mid_point        = {$urandom, $urandom};
        bus.point_cloud_size = 16'($urandom_range(0, 20));
      end
      if (c >= hold) bus.en = 1'b0;
      chk({v.name, "_busy"}, bus.busy, (c <= n));
      chk({v.name, "_done"}, bus.done, (c == n + 2));
      chk({v.name, "_wr_en"}, bus.wr_en, (c >= 2 && c <= n + 1));
      if (bus.wr_en && c >= 2 && c <= n + 1) begin
        k = c - 2;
        chk({v.name, "_wr_addr"}, bus.wr_addr, k);
        chk({v.name, "_wr_data"}, bus.wr_data, er[k]);
        got_data[k] = bus.wr_data;
      end
      if (c == n + 2) begin
        chk({v.name, "_counts"}, bus.counts, ecp);
        chk({v.name, "_oob"}, bus.oob_count, eo);
      end
    end
    // Results must hold after the batch returns to idle.
    chk({v.name, "_counts_hold"}, bus.counts, ecp);
    chk({v.name, "_oob_hold"}, bus.oob_count, eo);
  endtask

  task automatic chk_table(input vec_t v);
    for (int k = 0; k < v.n; k++)
      chk({v.name, "_tbl_rec"}, got_data[k], v.exp_data[k*4 +: 4]);
    chk({v.name, "_tbl_counts"}, bus.counts, v.exp_counts);
    chk({v.name, "_tbl_oob"}, bus.oob_count, v.exp_oob);
  endtask

  vec_t vecs [5];
  vec_t rv;
  int   seen;

  initial begin
    vecs[0].name = "spec";
    vecs[0].mid  = pt3(-2278, 6, -63);
    vecs[0].nbl  = pt3(-10113, -7972, -441);
    vecs[0].ftr  = pt3(5557, 7985, 315);
    vecs[0].size = 16'd4;
    vecs[0].px   = pts(257, -993, -272, -10112);
    vecs[0].py   = pts(-42, -154, -45, -7984);
    vecs[0].pz   = pts(-155, -154, -155, -313);
    vecs[0].n    = 4;
    vecs[0].exp_data   = 16'h0CCC;
    vecs[0].exp_counts = 128'(3) << 64;
    vecs[0].exp_oob    = 16'd1;

    vecs[1] = vecs[0];
    vecs[1].name = "size0";
    vecs[1].size = 16'd0;
    vecs[1].n    = 0;
    vecs[1].exp_data   = 16'h0000;
    vecs[1].exp_counts = '0;
    vecs[1].exp_oob    = 16'd0;

    vecs[2] = vecs[0];
    vecs[2].name = "size9";
    vecs[2].size = 16'd9;

    vecs[3] = vecs[0];
    vecs[3].name = "edges";
    vecs[3].px   = pts(-2278, 5557, -10113, 5558);
    vecs[3].py   = pts(6, 7985, -7972, 0);
    vecs[3].pz   = pts(-63, 315, -441, 0);
    vecs[3].exp_data   = 16'h58FF;
    vecs[3].exp_counts = (128'(2) << 112) | 128'(1);
    vecs[3].exp_oob    = 16'd1;

    vecs[4] = vecs[3];
    vecs[4].name = "size2";
    vecs[4].size = 16'd2;
    vecs[4].n    = 2;
    vecs[4].exp_data   = 16'h00FF;
    vecs[4].exp_counts = 128'(2) << 112;
    vecs[4].exp_oob    = 16'd0;

    bus.en = 1'b0;
    drive(vecs[0]);
    #22;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_batch(vecs[i], 1, 1'b0);
      chk_table(vecs[i]);
    end

    // Enable held high: a single batch, then a rerun after dropping enable.
    rv = vecs[0];
    rv.name = "hold";
    run_batch(rv, 110, 1'b0);
    chk_table(rv);
    rv.name = "rerun";
    run_batch(rv, 1, 1'b0);
    chk_table(rv);

    // Reset asserted after two records must abort at once.
    @(negedge clk);
    drive(vecs[0]);
    bus.en = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      if (bus.wr_en) seen++;
    end
    chk("abort_two_records", seen, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    rv = vecs[0];
    rv.name = "after_reset";
    run_batch(rv, 1, 1'b1);
    chk_table(rv);

    for (int i = 0; i < 25; i++) begin
      rv.name = "rand";
      rv.mid  = pt3($urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4, $urandom_range(0, 8) - 4);
      rv.nbl  = pt3(-int'($urandom_range(0, 6)), -int'($urandom_range(0, 6)),
                    -int'($urandom_range(0, 6)));
      rv.ftr  = pt3($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      rv.size = 16'($urandom_range(0, 6));
      rv.px   = pts($urandom_range(0, 16) - 8, $urandom_range(0, 16) - 8,
                    $urandom_range(0, 16) - 8, $urandom_range(0, 16) - 8);
      rv.py   = pts($urandom_range(0, 16) - 8, $urandom_range(0, 16) - 8,
                    $urandom_range(0, 16) - 8, $urandom_range(0, 16) - 8);
      rv.pz   = pts($urandom_range(0, 16) - 8, $urandom_range(0, 16) - 8,
                    $urandom_range(0, 16) - 8, $urandom_range(0, 16) - 8);
      run_batch(rv, int'($urandom_range(1, 8)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
